// File: rtl/id_ex_pipe_reg_if.sv
// id_ex_pipe_reg_if: decode-side inputs, hazard controls and execute-side
// outputs of the ID->EX pipeline register, bundled as one interface.
// master = decoder/hazard-unit side (drives D fields and StallE/FlushE),
// slave  = the pipeline register itself (drives the E fields).
interface id_ex_pipe_reg_if #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUCTRL_W  = 3,
  parameter int CNT_W      = 16
);
  // hazard-unit controls
  logic                  StallE;
  logic                  FlushE;

  // decode stage
  logic                  ValidD;
  logic                  RegWriteD;
  logic                  MemWriteD;
  logic                  JumpD;
  logic                  BranchD;
  logic                  ALUSrcD;
  logic [1:0]            ResultSrcD;
  logic [ALUCTRL_W-1:0]  ALUCtrlD;
  logic [2:0]            Funct3D;
  logic [WIDTH-1:0]      RD1D;
  logic [WIDTH-1:0]      RD2D;
  logic [WIDTH-1:0]      PCD;
  logic [WIDTH-1:0]      ImmExtD;
  logic [WIDTH-1:0]      PCPlus4D;
  logic [REG_ADDR_W-1:0] RdD;
  logic [REG_ADDR_W-1:0] Rs1D;
  logic [REG_ADDR_W-1:0] Rs2D;

  // execute stage
  logic                  ValidE;
  logic                  RegWriteE;
  logic                  MemWriteE;
  logic                  JumpE;
  logic                  BranchE;
  logic                  ALUSrcE;
  logic [1:0]            ResultSrcE;
  logic [ALUCTRL_W-1:0]  ALUCtrlE;
  logic [2:0]            Funct3E;
  logic [WIDTH-1:0]      RD1E;
  logic [WIDTH-1:0]      RD2E;
  logic [WIDTH-1:0]      PCE;
  logic [WIDTH-1:0]      ImmExtE;
  logic [WIDTH-1:0]      PCPlus4E;
  logic [REG_ADDR_W-1:0] RdE;
  logic [REG_ADDR_W-1:0] Rs1E;
  logic [REG_ADDR_W-1:0] Rs2E;
  logic [CNT_W-1:0]      BubbleCntE;
  logic [CNT_W-1:0]      StallCntE;

  modport master (
    output StallE, FlushE,
    output ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
    output ResultSrcD, ALUCtrlD, Funct3D,
    output RD1D, RD2D, PCD, ImmExtD, PCPlus4D, RdD, Rs1D, Rs2D,
    input  ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
    input  ResultSrcE, ALUCtrlE, Funct3E,
    input  RD1E, RD2E, PCE, ImmExtE, PCPlus4E, RdE, Rs1E, Rs2E,
    input  BubbleCntE, StallCntE
  );

  modport slave (
    input  StallE, FlushE,
    input  ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
    input  ResultSrcD, ALUCtrlD, Funct3D,
    input  RD1D, RD2D, PCD, ImmExtD, PCPlus4D, RdD, Rs1D, Rs2D,
    output ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
    output ResultSrcE, ALUCtrlE, Funct3E,
    output RD1E, RD2E, PCE, ImmExtE, PCPlus4E, RdE, Rs1E, Rs2E,
    output BubbleCntE, StallCntE
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID->EX pipeline register of the 5-stage RV32I core.
// Registers decode control, operand data and hazard register addresses with
// one cycle of latency. Edge priority: rst > FlushE (bubble) > StallE (hold)
// > load. A load of an invalid slot (ValidD=0) zeroes the control fields so
// it can never write the register file or memory, or redirect the PC.
// Optional bubble/stall performance counters are compiled in when the macro
// ID_EX_PERF_CNT_EN is defined; otherwise BubbleCntE/StallCntE are tied to 0.
module id_ex_pipe_reg #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUCTRL_W  = 3,
  parameter int CNT_W      = 16
) (
  input  logic            clk,
  input  logic            rst,
  id_ex_pipe_reg_if.slave bus
);

  typedef struct packed {
    logic                 reg_write;
    logic                 mem_write;
    logic                 jump;
    logic                 branch;
    logic                 alu_src;
    logic [1:0]           result_src;
    logic [ALUCTRL_W-1:0] alu_ctrl;
    logic [2:0]           funct3;
  } ctrl_t;

  typedef struct packed {
    logic [WIDTH-1:0]      rd1;
    logic [WIDTH-1:0]      rd2;
    logic [WIDTH-1:0]      pc;
    logic [WIDTH-1:0]      imm_ext;
    logic [WIDTH-1:0]      pc_plus4;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
  } data_t;

  ctrl_t ctrl_d, ctrl_q;
  data_t data_d, data_q;
  logic  valid_q;

  assign ctrl_d = '{
    reg_write:  bus.RegWriteD,
    mem_write:  bus.MemWriteD,
    jump:       bus.JumpD,
    branch:     bus.BranchD,
    alu_src:    bus.ALUSrcD,
    result_src: bus.ResultSrcD,
    alu_ctrl:   bus.ALUCtrlD,
    funct3:     bus.Funct3D
  };

  assign data_d = '{
    rd1:      bus.RD1D,
    rd2:      bus.RD2D,
    pc:       bus.PCD,
    imm_ext:  bus.ImmExtD,
    pc_plus4: bus.PCPlus4D,
    rd:       bus.RdD,
    rs1:      bus.Rs1D,
    rs2:      bus.Rs2D
  };

  // Pipeline register: clear on reset or flush, hold on stall, otherwise load.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking assignments here would make results depend on
    // statement order and race with other clocked blocks.
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (bus.FlushE) begin
      // Data and addresses are cleared too, so a bubble's Rs1E/Rs2E/RdE are
      // x0 and cannot produce a false forwarding match in the hazard unit.
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (!bus.StallE) begin
      valid_q <= bus.ValidD;
      ctrl_q  <= bus.ValidD ? ctrl_d : '0;
      data_q  <= data_d;
    end
  end

  assign bus.ValidE     = valid_q;
  assign bus.RegWriteE  = ctrl_q.reg_write;
  assign bus.MemWriteE  = ctrl_q.mem_write;
  assign bus.JumpE      = ctrl_q.jump;
  assign bus.BranchE    = ctrl_q.branch;
  assign bus.ALUSrcE    = ctrl_q.alu_src;
  assign bus.ResultSrcE = ctrl_q.result_src;
  assign bus.ALUCtrlE   = ctrl_q.alu_ctrl;
  assign bus.Funct3E    = ctrl_q.funct3;
  assign bus.RD1E       = data_q.rd1;
  assign bus.RD2E       = data_q.rd2;
  assign bus.PCE        = data_q.pc;
  assign bus.ImmExtE    = data_q.imm_ext;
  assign bus.PCPlus4E   = data_q.pc_plus4;
  assign bus.RdE        = data_q.rd;
  assign bus.Rs1E       = data_q.rs1;
  assign bus.Rs2E       = data_q.rs2;

`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] stall_cnt;

  // Saturating counters: bubbles on every flush edge, stalls on every
  // stall edge that is not overridden by a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else if (bus.FlushE) begin
      if (bubble_cnt != {CNT_W{1'b1}}) bubble_cnt <= bubble_cnt + 1'b1;
    end else if (bus.StallE) begin
      if (stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.BubbleCntE = bubble_cnt;
  assign bus.StallCntE  = stall_cnt;
`else
  assign bus.BubbleCntE = {CNT_W{1'b0}};
  assign bus.StallCntE  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: table-driven check of id_ex_pipe_reg plus hand-written
// sequences for async reset, stall hold, flush priority, control gating and
// the optional perf counters (expected values depend on ID_EX_PERF_CNT_EN).
module tb_id_ex_pipe_reg;

  localparam int W    = 32;
  localparam int AW   = 5;
  localparam int CW   = 3;
  localparam int NW   = 2;
  localparam int CMAX = (1 << NW) - 1;
`ifdef ID_EX_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  // ctrl bits: {RegWrite, MemWrite, Jump, Branch, ALUSrc, ResultSrc[1:0],
  //             ALUCtrl[2:0], Funct3[2:0]}
  typedef struct packed {
    logic [W-1:0]  rd1, rd2, pc, imm, pc4;
    logic [AW-1:0] rd, rs1, rs2;
  } d_t;

  typedef struct packed {
    logic        stall, flush, valid;
    logic [12:0] ctrl;
    d_t          d;
    logic        e_valid;
    logic [12:0] e_ctrl;
    d_t          e_d;
  } vec_t;

  typedef struct packed {
    logic          valid;
    logic [12:0]   ctrl;
    d_t            d;
    logic [NW-1:0] bub, stl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_pipe_reg_if #(.WIDTH(W), .REG_ADDR_W(AW), .ALUCTRL_W(CW), .CNT_W(NW)) bus ();

  id_ex_pipe_reg #(.WIDTH(W), .REG_ADDR_W(AW), .ALUCTRL_W(CW), .CNT_W(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  int   exp_bub  = 0;
  int   exp_stl  = 0;
  exp_t sb[$];
  vec_t tbl[11];

  function automatic d_t mk(input logic [31:0] seed);
    d_t d;
    d.rd1 = seed;
    d.rd2 = seed ^ 32'h5A5A_5A5A;
    d.pc  = seed + 32'h100;
    d.imm = ~seed;
    d.pc4 = seed + 32'h104;
    d.rd  = seed[4:0];
    d.rs1 = seed[9:5];
    d.rs2 = seed[14:10];
    return d;
  endfunction

  function automatic vec_t mkv(input logic s, input logic f, input logic v,
                               input logic [12:0] c, input logic [31:0] seed,
                               input logic ev, input logic [12:0] ec,
                               input logic [31:0] eseed, input logic ez);
    vec_t r;
    r.stall = s; r.flush = f; r.valid = v; r.ctrl = c; r.d = mk(seed);
    r.e_valid = ev; r.e_ctrl = ec; r.e_d = ez ? '0 : mk(eseed);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic compare_now(input exp_t e, input string tag);
    check({tag, ".valid"}, 32'(bus.ValidE), 32'(e.valid));
    check({tag, ".ctrl"}, 32'({bus.RegWriteE, bus.MemWriteE, bus.JumpE, bus.BranchE,
                               bus.ALUSrcE, bus.ResultSrcE, bus.ALUCtrlE, bus.Funct3E}),
          32'(e.ctrl));
    check({tag, ".rd1"}, bus.RD1E, e.d.rd1);
    check({tag, ".rd2"}, bus.RD2E, e.d.rd2);
    check({tag, ".pc"},  bus.PCE, e.d.pc);
    check({tag, ".imm"}, bus.ImmExtE, e.d.imm);
    check({tag, ".pc4"}, bus.PCPlus4E, e.d.pc4);
    check({tag, ".rd"},  32'(bus.RdE), 32'(e.d.rd));
    check({tag, ".rs1"}, 32'(bus.Rs1E), 32'(e.d.rs1));
    check({tag, ".rs2"}, 32'(bus.Rs2E), 32'(e.d.rs2));
    check({tag, ".bub"}, 32'(bus.BubbleCntE), 32'(e.bub));
    check({tag, ".stl"}, 32'(bus.StallCntE), 32'(e.stl));
  endtask

  function automatic exp_t zero_exp();
    return '0;
  endfunction

  task automatic drive(input vec_t v);
    bus.StallE = v.stall;
    bus.FlushE = v.flush;
    bus.ValidD = v.valid;
    {bus.RegWriteD, bus.MemWriteD, bus.JumpD, bus.BranchD, bus.ALUSrcD,
     bus.ResultSrcD, bus.ALUCtrlD, bus.Funct3D} = v.ctrl;
    bus.RD1D = v.d.rd1; bus.RD2D = v.d.rd2; bus.PCD = v.d.pc;
    bus.ImmExtD = v.d.imm; bus.PCPlus4D = v.d.pc4;
    bus.RdD = v.d.rd; bus.Rs1D = v.d.rs1; bus.Rs2D = v.d.rs2;
  endtask

  // Drive one cycle of stimulus, push the expected post-edge state, then pop
  // and compare it one edge later.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    drive(v);
    if (v.flush) begin
      if (exp_bub < CMAX) exp_bub++;
    end else if (v.stall) begin
      if (exp_stl < CMAX) exp_stl++;
    end
    e.valid = v.e_valid;
    e.ctrl  = v.e_ctrl;
    e.d     = v.e_d;
    e.bub   = PERF_EN ? NW'(exp_bub) : '0;
    e.stl   = PERF_EN ? NW'(exp_stl) : '0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      compare_now(sb.pop_front(), tag);
    end
  endtask

  // Assert rst between edges (called at posedge+1), check the immediate
  // clear, hold it across one edge, release at the falling edge.
  task automatic do_reset(input string tag);
    #1;
    rst = 1'b1;
    #1;
    exp_bub = 0;
    exp_stl = 0;
    compare_now(zero_exp(), {tag, ".async"});
    @(posedge clk);
    #1;
    compare_now(zero_exp(), {tag, ".held"});
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;

    tbl[0]  = mkv(0, 0, 1, 13'h1ABC, 32'h1111_0001, 1, 13'h1ABC, 32'h1111_0001, 0);
    tbl[1]  = mkv(0, 0, 0, 13'h1FFF, 32'h2222_0002, 0, 13'h0000, 32'h2222_0002, 0);
    tbl[2]  = mkv(0, 0, 1, 13'h0555, 32'h3333_0003, 1, 13'h0555, 32'h3333_0003, 0);
    tbl[3]  = mkv(1, 0, 1, 13'h0AAA, 32'h4444_0004, 1, 13'h0555, 32'h3333_0003, 0);
    tbl[4]  = mkv(1, 0, 0, 13'h1234, 32'h5555_0005, 1, 13'h0555, 32'h3333_0003, 0);
    tbl[5]  = mkv(0, 1, 1, 13'h1FFF, 32'h6666_0006, 0, 13'h0000, 32'h0, 1);
    tbl[6]  = mkv(1, 1, 1, 13'h1FFF, 32'h7777_0007, 0, 13'h0000, 32'h0, 1);
    tbl[7]  = mkv(0, 0, 1, 13'h0F0F, 32'h8888_0008, 1, 13'h0F0F, 32'h8888_0008, 0);
    tbl[8]  = mkv(1, 0, 0, 13'h0000, 32'h9999_0009, 1, 13'h0F0F, 32'h8888_0008, 0);
    tbl[9]  = mkv(0, 0, 1, 13'h1001, 32'hAAAA_000A, 1, 13'h1001, 32'hAAAA_000A, 0);
    tbl[10] = mkv(0, 0, 0, 13'h0000, 32'hBBBB_000B, 0, 13'h0000, 32'hBBBB_000B, 0);

    // Reset state with every D input nonzero.
    drive(mkv(0, 0, 1, 13'h1FFF, 32'hFFFF_FFFF, 0, 0, 0, 1));
    #3;
    compare_now(zero_exp(), "reset_init");
    @(posedge clk);
    #1;
    compare_now(zero_exp(), "reset_held");
    @(negedge clk);
    rst = 1'b0;

    // Pass-through: RegWrite, ALUCtrl=010, RD1=DEADBEEF, Rd=7.
    v = mkv(0, 0, 1, 13'h1010, 32'h0000_1234, 1, 13'h1010, 32'h0000_1234, 0);
    v.d.rd1 = 32'hDEAD_BEEF; v.d.rd = 5'd7;
    v.e_d = v.d;
    apply(v, "passthru");

    // Table-driven vectors.
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Stall: load PC 100, hold through 104/108/10C, release loads 10C.
    apply(mkv(0, 0, 1, 13'h1A5A, 32'h0, 1, 13'h1A5A, 32'h0, 0), "stall.load");
    apply(mkv(1, 0, 1, 13'h0001, 32'h4, 1, 13'h1A5A, 32'h0, 0), "stall.c1");
    apply(mkv(1, 0, 1, 13'h0002, 32'h8, 1, 13'h1A5A, 32'h0, 0), "stall.c2");
    apply(mkv(1, 0, 1, 13'h0003, 32'hC, 1, 13'h1A5A, 32'h0, 0), "stall.c3");
    check("stall.pc_held", bus.PCE, 32'h100);
    apply(mkv(0, 0, 1, 13'h0003, 32'hC, 1, 13'h0003, 32'hC, 0), "stall.release");
    check("stall.pc_release", bus.PCE, 32'h10C);

    // Flush overrides a simultaneous stall, MemWriteD=1 must not leak.
    apply(mkv(0, 0, 1, 13'h1FFF, 32'h0F0F_3C3C, 1, 13'h1FFF, 32'h0F0F_3C3C, 0), "flushpri.load");
    apply(mkv(1, 1, 1, 13'h0800, 32'h1357_9BDF, 0, 13'h0000, 32'h0, 1), "flushpri");

    // Control gating: invalid slot with RegWrite/MemWrite/Jump set, RD2=55.
    v = mkv(0, 0, 0, 13'h1C00, 32'h2468_ACE0, 0, 13'h0000, 32'h0, 0);
    v.d.rd2 = 32'h55;
    v.e_d = v.d;
    apply(v, "gating");
    check("gating.rd2", bus.RD2E, 32'h55);

    // Reset asserted mid-stall, then a normal load after release.
    apply(mkv(0, 0, 1, 13'h0F00, 32'hCAFE_0011, 1, 13'h0F00, 32'hCAFE_0011, 0), "midstall.load");
    apply(mkv(1, 0, 1, 13'h00FF, 32'hCAFE_0022, 1, 13'h0F00, 32'hCAFE_0011, 0), "midstall.hold");
    do_reset("midstall.rst");
    apply(mkv(0, 0, 1, 13'h0AA5, 32'hCAFE_0033, 1, 13'h0AA5, 32'hCAFE_0033, 0), "midstall.reload");

    // Perf counters from a clean reset: 5 flushes then 2 stalls.
    do_reset("perf.rst");
    for (int i = 0; i < 5; i++)
      apply(mkv(0, 1, 1, 13'h1FFF, 32'h1000 + 32'(i), 0, 13'h0000, 32'h0, 1),
            $sformatf("perf.flush%0d", i));
    check("perf.bubble_sat", 32'(bus.BubbleCntE), PERF_EN ? 32'd3 : 32'd0);
    for (int i = 0; i < 2; i++)
      apply(mkv(1, 0, 1, 13'h1FFF, 32'h2000 + 32'(i), 0, 13'h0000, 32'h0, 1),
            $sformatf("perf.stall%0d", i));
    check("perf.stall_cnt", 32'(bus.StallCntE), PERF_EN ? 32'd2 : 32'd0);
    check("perf.bubble_kept", 32'(bus.BubbleCntE), PERF_EN ? 32'd3 : 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Parametrised successor to the team's ID→EX pipeline register for the 5-stage RV32I core.
- Captures decode-stage control, operand data and hazard register addresses each cycle.
- Adds the following over the previous single-mode register:
  - hold (stall) and bubble (flush) control;
  - a valid bit;
  - control gating for invalid instructions;
  - parametrised field widths.
- Sits between the decoder/register file and the execute stage; driven by the hazard unit.

Parameters:
- WIDTH, 32, data path width (RD1/RD2/PC/ImmExt/PCPlus4)
- REG_ADDR_W, 5, register address width (Rd/Rs1/Rs2)
- ALUCTRL_W, 3, ALU control field width
- CNT_W, 16, perf counter width (optional feature only)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- StallE  in  1  hold current E contents
- FlushE  in  1  insert bubble
- ValidD  in  1  D-stage holds a real instruction
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1 each  decode control
- ResultSrcD  in  2  result mux select
- ALUCtrlD  in  ALUCTRL_W  ALU operation
- Funct3D  in  3  funct3 for branch/load-store sizing
- RD1D, RD2D, PCD, ImmExtD, PCPlus4D  in  WIDTH each  decode data
- RdD, Rs1D, Rs2D  in  REG_ADDR_W each  register addresses
- ValidE  out  1  E-stage holds a real instruction
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUCtrlE, Funct3E  out  matching widths  registered control
- RD1E, RD2E, PCE, ImmExtE, PCPlus4E, RdE, Rs1E, Rs2E  out  matching widths  registered data/addresses
- BubbleCntE  out  CNT_W  bubbles inserted (optional feature)
- StallCntE  out  CNT_W  stall cycles (optional feature)

Behaviour:
- Reset:
  - One clock domain, clk.
  - rst is asynchronous and active-high: assertion immediately clears every output to 0, including ValidE and the counters, regardless of clk.
  - Deassertion is sampled on clk; the first load occurs at the first rising edge with rst low.
- Latency: exactly 1 cycle D→E when not stalled or flushed.
- Priority on each rising edge: rst > FlushE > StallE > load.
- FlushE=1 (bubble):
  - ValidE and all control outputs go to 0: RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUCtrlE, Funct3E.
  - Data and address outputs also go to 0, so Rs1E=Rs2E=RdE=0 and no false forwarding matches occur.
  - FlushE overrides a simultaneous StallE.
- StallE=1, FlushE=0: all outputs hold their values; D inputs are ignored.
- Load (StallE=0, FlushE=0):
  - ValidE<=ValidD.
  - Data and address outputs <= D inputs, unconditionally.
  - Control outputs <= D controls when ValidD=1.
  - Control outputs <= 0 when ValidD=0 (control gating): an invalid slot can never write the register file or memory, or redirect the PC.
- No combinational path from any input to any output; all outputs come straight from flops.
- Width rules: fields are copied verbatim, with no extension or truncation.
- Reset asserted mid-stall or mid-flush: the async clear wins; the next load after release proceeds normally.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined:
  - BubbleCntE increments on every edge where FlushE=1.
  - StallCntE increments on every edge where StallE=1 and FlushE=0.
  - Both counters saturate at 2^CNT_W-1 (no wrap).
  - Both counters clear on rst.
- Undefined: the counter logic is absent, the ports remain present, and both are tied to 0.

Test Plan:
- Reset: drive all D inputs to nonzero, assert rst between clock edges → all outputs read 0 immediately, before the next edge; release rst → next edge loads D values.
- Pass-through: ValidD=1, RegWriteD=1, ALUCtrlD=3'b010, RD1D=32'hDEADBEEF, RdD=5'd7 → one edge later ValidE=1, RegWriteE=1, ALUCtrlE=3'b010, RD1E=32'hDEADBEEF, RdE=7.
- Stall: load PCD=32'h100, then StallE=1 for 3 cycles while PCD=32'h104/108/10C → PCE stays 32'h100; StallE=0 → PCE=32'h10C next edge.
- Flush priority: StallE=1 and FlushE=1 together, with MemWriteD=1 → next edge ValidE=0, MemWriteE=0, Rs1E=0, Rs2E=0.
- Control gating: ValidD=0, RegWriteD=1, MemWriteD=1, JumpD=1, RD2D=32'h55 → RegWriteE=MemWriteE=JumpE=0, ValidE=0, RD2E=32'h55.
- Perf counters (with ID_EX_PERF_CNT_EN, CNT_W=2): 5 flush cycles → BubbleCntE=3, saturated; 2 stall cycles → StallCntE=2. Without the macro, both counters read 0 throughout.
